pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. Sequences the enables and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from hazards seen in ID, EX and MEM: load-use stalls, taken-branch flushes and multi-cycle data-memory waits with a timeout. Sits beside the pipeline registers; every stage register takes its write-enable/flush from this block.

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage pipeline.
// Drives write-enables and bubble/flush controls for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB from load-use, taken-branch and data-memory-wait hazards.
// Optional feature macro: PIPE_HAZARD_PERF_EN enables the saturating
// stall-cycle counter on StallCount; otherwise StallCount reads zero.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  IdRs,
   input  logic [4:0]  IdRt,
   input  logic        ExMemRead,
   input  logic [4:0]  ExRt,
   input  logic        ExBranchTaken,
   input  logic        MemReq,
   input  logic        MemReady,
   output logic        PcWrite,
   output logic        IfIdWrite,
   output logic        IfIdFlush,
   output logic        IdExEn,
   output logic        IdExFlush,
   output logic        ExMemEn,
   output logic        MemWbEn,
   output logic        MemWbBubble,
   output logic        MemTimeout,
   output logic [15:0] StallCount
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       load_use;

   // A load in EX whose destination feeds either ID source operand; r0 never hazards.
   always_comb begin
      load_use = ExMemRead && (ExRt != 5'd0) && ((ExRt == IdRs) || (ExRt == IdRt));
   end

   // Next-state, wait counter and same-cycle control outputs from state and hazards.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      PcWrite     = 1'b1;
      IfIdWrite   = 1'b1;
      IfIdFlush   = 1'b0;
      IdExEn      = 1'b1;
      IdExFlush   = 1'b0;
      ExMemEn     = 1'b1;
      MemWbEn     = 1'b1;
      MemWbBubble = 1'b0;
      MemTimeout  = 1'b0;

      case (state_q)
         RUN: begin
            if (MemReq && !MemReady) begin
               PcWrite     = 1'b0;
               IfIdWrite   = 1'b0;
               IdExEn      = 1'b0;
               ExMemEn     = 1'b0;
               MemWbBubble = 1'b1;
               state_d     = MEM_WAIT;
               wait_cnt_d  = 8'd1;
            end else if (ExBranchTaken) begin
               IfIdFlush = 1'b1;
               IdExFlush = 1'b1;
            end else if (load_use) begin
               PcWrite   = 1'b0;
               IfIdWrite = 1'b0;
               IdExFlush = 1'b1;
            end
         end

         MEM_WAIT: begin
            if (MemReady) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else begin
               PcWrite     = 1'b0;
               IfIdWrite   = 1'b0;
               IdExEn      = 1'b0;
               ExMemEn     = 1'b0;
               MemWbBubble = 1'b1;
               if (wait_cnt_q == TIMEOUT_VAL) begin
                  state_d = ERROR;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
         end

         ERROR: begin
            PcWrite     = 1'b0;
            IfIdWrite   = 1'b0;
            IdExEn      = 1'b0;
            ExMemEn     = 1'b0;
            MemWbEn     = 1'b0;
            MemWbBubble = 1'b1;
            MemTimeout  = 1'b1;
         end

         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase

      if (Reset) begin
         state_d     = RUN;
         wait_cnt_d  = 8'd0;
         PcWrite     = 1'b0;
         IfIdWrite   = 1'b0;
         IfIdFlush   = 1'b1;
         IdExEn      = 1'b0;
         IdExFlush   = 1'b1;
         ExMemEn     = 1'b0;
         MemWbEn     = 1'b0;
         MemWbBubble = 1'b1;
         MemTimeout  = 1'b0;
      end
   end

   // FSM state and memory-wait counter registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= RUN;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Count every cycle the PC is held, saturating instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!PcWrite && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;
`else
   assign StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT overridden to 4).
// Build with PIPE_HAZARD_PERF_EN to also check the stall counter values
// and the 16-bit saturation run.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Packed control order: PcWrite,IfIdWrite,IfIdFlush,IdExEn,IdExFlush,
   // ExMemEn,MemWbEn,MemWbBubble,MemTimeout
   localparam logic [8:0] C_RUN   = 9'b110101100;
   localparam logic [8:0] C_RESET = 9'b001010010;
   localparam logic [8:0] C_LDUSE = 9'b000111100;
   localparam logic [8:0] C_BRNCH = 9'b111111100;
   localparam logic [8:0] C_MWAIT = 9'b000000110;
   localparam logic [8:0] C_ERROR = 9'b000000011;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  IdRs, IdRt, ExRt;
   logic        ExMemRead, ExBranchTaken, MemReq, MemReady;
   logic        PcWrite, IfIdWrite, IfIdFlush, IdExEn, IdExFlush;
   logic        ExMemEn, MemWbEn, MemWbBubble, MemTimeout;
   logic [15:0] StallCount;
   logic [8:0]  ctrl;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] stall_model = 16'h0;
   logic [15:0] exp_sc;

   assign ctrl = {PcWrite, IfIdWrite, IfIdFlush, IdExEn, IdExFlush,
                  ExMemEn, MemWbEn, MemWbBubble, MemTimeout};

   always #5 Clk = ~Clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .Clk(Clk), .Reset(Reset), .IdRs(IdRs), .IdRt(IdRt),
      .ExMemRead(ExMemRead), .ExRt(ExRt), .ExBranchTaken(ExBranchTaken),
      .MemReq(MemReq), .MemReady(MemReady), .PcWrite(PcWrite),
      .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush), .IdExEn(IdExEn),
      .IdExFlush(IdExFlush), .ExMemEn(ExMemEn), .MemWbEn(MemWbEn),
      .MemWbBubble(MemWbBubble), .MemTimeout(MemTimeout),
      .StallCount(StallCount)
   );

   task automatic idle_inputs();
      Reset = 1'b0; IdRs = 5'd0; IdRt = 5'd0; ExRt = 5'd0;
      ExMemRead = 1'b0; ExBranchTaken = 1'b0; MemReq = 1'b0; MemReady = 1'b0;
   endtask

   // Advance one clock; the model counts the cycle as a stall if told so.
   task automatic tick(input bit stalled);
      @(posedge Clk);
      if (Reset) stall_model = 16'h0;
      else if (stalled && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      Reset = 1'b1; MemReq = 1'b1; ExBranchTaken = 1'b1;
      tick(1'b0);
      #1;
      checks++;
      if (ctrl !== C_RESET) begin
         errors++; $display("[TB] FAIL reset_ctrl got %b want %b", ctrl, C_RESET);
      end
      idle_inputs();
      tick(1'b0);
      #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL reset_run got %b want %b", ctrl, C_RUN);
      end
      checks++;
      if (StallCount !== 16'h0) begin
         errors++; $display("[TB] FAIL reset_stallcount got %h want 0000", StallCount);
      end
   endtask

   task automatic test_load_use();
      idle_inputs();
      ExMemRead = 1'b1; ExRt = 5'd5; IdRs = 5'd5; #1;
      checks++;
      if (ctrl !== C_LDUSE) begin
         errors++; $display("[TB] FAIL loaduse_rs got %b want %b", ctrl, C_LDUSE);
      end
      tick(1'b1);
      ExMemRead = 1'b0; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL loaduse_one_cycle got %b want %b", ctrl, C_RUN);
      end
      ExMemRead = 1'b1; ExRt = 5'd7; IdRs = 5'd3; IdRt = 5'd7; #1;
      checks++;
      if (ctrl !== C_LDUSE) begin
         errors++; $display("[TB] FAIL loaduse_rt got %b want %b", ctrl, C_LDUSE);
      end
      tick(1'b1);
      ExRt = 5'd0; IdRs = 5'd0; IdRt = 5'd0; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL loaduse_r0 got %b want %b", ctrl, C_RUN);
      end
      ExRt = 5'd9; IdRs = 5'd8; IdRt = 5'd10; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL loaduse_nomatch got %b want %b", ctrl, C_RUN);
      end
      tick(1'b0);
      idle_inputs(); #1;
      exp_sc = PERF ? stall_model : 16'h0;
      checks++;
      if (StallCount !== exp_sc) begin
         errors++; $display("[TB] FAIL loaduse_stallcount got %0d want %0d", StallCount, exp_sc);
      end
   endtask

   task automatic test_branch();
      idle_inputs();
      ExBranchTaken = 1'b1; ExMemRead = 1'b1; ExRt = 5'd4; IdRt = 5'd4; #1;
      checks++;
      if (ctrl !== C_BRNCH) begin
         errors++; $display("[TB] FAIL branch_over_loaduse got %b want %b", ctrl, C_BRNCH);
      end
      tick(1'b0);
      idle_inputs(); #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL branch_after got %b want %b", ctrl, C_RUN);
      end
   endtask

   task automatic test_mem_wait();
      idle_inputs();
      MemReady = 1'b1; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL ready_without_req got %b want %b", ctrl, C_RUN);
      end
      MemReq = 1'b1; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL req_ready_same got %b want %b", ctrl, C_RUN);
      end
      tick(1'b0);
      MemReady = 1'b0; ExBranchTaken = 1'b1; #1;
      checks++;
      if (ctrl !== C_MWAIT) begin
         errors++; $display("[TB] FAIL memwait_entry got %b want %b", ctrl, C_MWAIT);
      end
      tick(1'b1);
      ExMemRead = 1'b1; ExRt = 5'd2; IdRs = 5'd2; #1;
      checks++;
      if (ctrl !== C_MWAIT) begin
         errors++; $display("[TB] FAIL memwait_ignores_hazards got %b want %b", ctrl, C_MWAIT);
      end
      tick(1'b1);
      idle_inputs(); MemReq = 1'b1; MemReady = 1'b1; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL memwait_release got %b want %b", ctrl, C_RUN);
      end
      tick(1'b0);
      idle_inputs(); #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL memwait_back_in_run got %b want %b", ctrl, C_RUN);
      end
      exp_sc = PERF ? stall_model : 16'h0;
      checks++;
      if (StallCount !== exp_sc) begin
         errors++; $display("[TB] FAIL memwait_stallcount got %0d want %0d", StallCount, exp_sc);
      end
   endtask

   task automatic test_ready_at_timeout();
      idle_inputs();
      MemReq = 1'b1;
      tick(1'b1);
      for (int i = 1; i <= 3; i++) begin
         #1;
         checks++;
         if (ctrl !== C_MWAIT) begin
            errors++; $display("[TB] FAIL boundary_wait%0d got %b want %b", i, ctrl, C_MWAIT);
         end
         tick(1'b1);
      end
      MemReady = 1'b1; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL boundary_ready_wins got %b want %b", ctrl, C_RUN);
      end
      tick(1'b0);
      idle_inputs(); #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL boundary_no_error got %b want %b", ctrl, C_RUN);
      end
   endtask

   task automatic enter_error();
      idle_inputs();
      MemReq = 1'b1;
      tick(1'b1);
      for (int i = 1; i <= 4; i++) tick(1'b1);
   endtask

   task automatic test_timeout();
      idle_inputs();
      MemReq = 1'b1;
      tick(1'b1);
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++;
         if (ctrl !== C_MWAIT) begin
            errors++; $display("[TB] FAIL timeout_wait%0d got %b want %b", i, ctrl, C_MWAIT);
         end
         tick(1'b1);
      end
      #1;
      checks++;
      if (ctrl !== C_ERROR) begin
         errors++; $display("[TB] FAIL timeout_error got %b want %b", ctrl, C_ERROR);
      end
      MemReq = 1'b0; MemReady = 1'b1; ExBranchTaken = 1'b1;
      tick(1'b1);
      tick(1'b1);
      #1;
      checks++;
      if (ctrl !== C_ERROR) begin
         errors++; $display("[TB] FAIL timeout_held got %b want %b", ctrl, C_ERROR);
      end
      exp_sc = PERF ? stall_model : 16'h0;
      checks++;
      if (StallCount !== exp_sc) begin
         errors++; $display("[TB] FAIL timeout_stallcount got %0d want %0d", StallCount, exp_sc);
      end
   endtask

   task automatic test_reset_in_error();
      idle_inputs();
      Reset = 1'b1; #1;
      checks++;
      if (ctrl !== C_RESET) begin
         errors++; $display("[TB] FAIL err_reset_ctrl got %b want %b", ctrl, C_RESET);
      end
      tick(1'b0);
      Reset = 1'b0; #1;
      checks++;
      if (ctrl !== C_RUN) begin
         errors++; $display("[TB] FAIL err_reset_run got %b want %b", ctrl, C_RUN);
      end
      checks++;
      if (StallCount !== 16'h0) begin
         errors++; $display("[TB] FAIL err_reset_stallcount got %h want 0000", StallCount);
      end
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      MemReq = 1'b1;
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      Reset = 1'b1;
      tick(1'b0);
      Reset = 1'b0;
      // Counter must restart: four fresh wait cycles before any error.
      tick(1'b1);
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++;
         if (ctrl !== C_MWAIT) begin
            errors++; $display("[TB] FAIL midwait_reset_wait%0d got %b want %b", i, ctrl, C_MWAIT);
         end
         tick(1'b1);
      end
      #1;
      checks++;
      if (ctrl !== C_ERROR) begin
         errors++; $display("[TB] FAIL midwait_reset_error got %b want %b", ctrl, C_ERROR);
      end
      Reset = 1'b1;
      tick(1'b0);
      idle_inputs();
   endtask

   task automatic test_saturation();
      enter_error();
      for (int i = 0; i < 70000; i++) tick(1'b1);
      #1;
      exp_sc = PERF ? stall_model : 16'h0;
      checks++;
      if (StallCount !== exp_sc) begin
         errors++; $display("[TB] FAIL saturation got %h want %h", StallCount, exp_sc);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_ready_at_timeout();
      test_timeout();
      test_reset_in_error();
      test_reset_mid_wait();
      if (PERF) test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
